// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if
//   Bundles the signals between the gate exerciser, the two-input gate block
//   it drives, and whoever requests runs and reads the diagnostics.
//   master : the exerciser (drives a/b and all status, reads start and y0..y6)
//   slave  : the environment (drives start and the gate outputs, reads status)
//   Signals:
//     start            run request, level-sampled while idle
//     a, b             stimulus to the gate block
//     y0..y6           gate-block outputs
//     busy, done       run in progress / one-cycle end-of-run pulse
//     pass             last run had no mismatching vector
//     err_count        mismatching vectors in the last run (saturating)
//     fail_vec         sticky per-output mismatch bits, bit i = yi
//     first_fail_idx   {a,b} of the first mismatching vector
//     first_fail_valid first_fail_idx holds a captured value
interface gate_exerciser_if;
  logic       start;
  logic       a;
  logic       b;
  logic       y0;
  logic       y1;
  logic       y2;
  logic       y3;
  logic       y4;
  logic       y5;
  logic       y6;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [6:0] fail_vec;
  logic [1:0] first_fail_idx;
  logic       first_fail_valid;

  modport master (
    input  start, y0, y1, y2, y3, y4, y5, y6,
    output a, b, busy, done, pass, err_count, fail_vec,
           first_fail_idx, first_fail_valid
  );

  modport slave (
    output start, y0, y1, y2, y3, y4, y5, y6,
    input  a, b, busy, done, pass, err_count, fail_vec,
           first_fail_idx, first_fail_valid
  );
endinterface

// File: rtl/gate_exerciser.sv
// gate_exerciser
//   Walks a two-input gate block through {a,b} = 00,01,10,11 for LOOPS sweeps,
//   waits SETTLE cycles per vector, samples y0..y6 and compares them against
//   the AND/OR/NAND/NOR/XOR/XNOR/NOT truth table. Reports pass/fail, a
//   saturating mismatch count and first-failure diagnostics.
//   Parameters: SETTLE (1..255) settle cycles, LOOPS (1..65535) sweeps per run.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  gate_exerciser_if.master (start, a/b, y0..y6, status/diagnostics)
module gate_exerciser #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LOOPS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  gate_exerciser_if.master  bus
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_SETTLE   = 2'd1;
  localparam logic [1:0]  ST_SAMPLE   = 2'd2;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] LOOP_LAST   = 16'(LOOPS - 1);

  // Expected gate outputs for one input vector, bit i = yi.
  function automatic logic [6:0] gate_expect(input logic a, input logic b);
    gate_expect = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] loop_q, loop_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [6:0]  fail_q, fail_d;
  logic [1:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;
  logic [6:0]  y_s;
  logic [6:0]  mism_s;
  logic        last_vec_s;

  assign y_s        = {bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
  assign mism_s     = y_s ^ gate_expect(a_q, b_q);
  assign last_vec_s = ({a_q, b_q} == 2'b11) && (loop_q == LOOP_LAST);

  // Next-state logic for the run sequencer and all diagnostics.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    loop_d   = loop_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          a_d      = 1'b0;
          b_d      = 1'b0;
          busy_d   = 1'b1;
          settle_d = 8'd0;
          loop_d   = 16'd0;
          err_d    = 8'd0;
          fail_d   = 7'd0;
          ffv_d    = 1'b0;
          pass_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        fail_d = fail_q | mism_s;
        // One count per failing vector; hold at 255 instead of wrapping.
        if ((mism_s != 7'd0) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end else begin
          err_d = err_q;
        end
        if ((mism_s != 7'd0) && !ffv_q) begin
          ffi_d = {a_q, b_q};
          ffv_d = 1'b1;
        end else begin
          ffi_d = ffi_q;
          ffv_d = ffv_q;
        end
        if (last_vec_s) begin
          state_d = ST_IDLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d  = ST_SETTLE;
          {a_d, b_d} = {a_q, b_q} + 2'd1;
          settle_d = 8'd0;
          if ({a_q, b_q} == 2'b11) begin
            loop_d = loop_q + 16'd1;
          end else begin
            loop_d = loop_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= 8'd0;
      loop_q   <= 16'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 8'd0;
      fail_q   <= 7'd0;
      ffi_q    <= 2'd0;
      ffv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      loop_q   <= loop_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
    end
  end

  assign bus.a                = a_q;
  assign bus.b                = b_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.fail_vec         = fail_q;
  assign bus.first_fail_idx   = ffi_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser
//   Two exercisers on a shared clock/reset: u_dut (SETTLE=2, LOOPS=1) is
//   tracked cycle by cycle against a reference timing model with a scoreboard
//   of expected vectors and run results; u_sat (LOOPS=100) faces an all-inverted
//   gate model to cover error-count saturation.
module tb_gate_exerciser;
  localparam int S      = 2;
  localparam int L      = 1;
  localparam int RUNLEN = 4 * L * (S + 1);

  typedef struct packed {
    logic [7:0] err;
    logic [6:0] fv;
    logic [1:0] ffi;
    logic       ffv;
    logic       pass;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   mode1;
  int   mode2;

  gate_exerciser_if bus1 ();
  gate_exerciser_if bus2 ();

  gate_exerciser #(.SETTLE(S), .LOOPS(L))   u_dut (.clk(clk), .rst(rst), .bus(bus1));
  gate_exerciser #(.SETTLE(S), .LOOPS(100)) u_sat (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec truth table, bit i = yi.
  function automatic logic [6:0] truth(input logic a, input logic b);
    truth = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  // Gate block model: 0 correct, 1 y4 stuck at 0, 2 all outputs inverted.
  function automatic logic [6:0] gate_out(input int mode, input logic a, input logic b);
    logic [6:0] t;
    t = truth(a, b);
    if (mode == 1) t[4] = 1'b0;
    if (mode == 2) t = ~t;
    return t;
  endfunction

  // Expected end-of-run diagnostics for a given fault mode and loop count.
  function automatic res_t expect_run(input int mode, input int loops);
    res_t r;
    logic [6:0] m;
    logic [1:0] v;
    r = '0;
    for (int l = 0; l < loops; l++) begin
      for (int n = 0; n < 4; n++) begin
        v = 2'(n);
        m = gate_out(mode, v[1], v[0]) ^ truth(v[1], v[0]);
        r.fv = r.fv | m;
        if (m != 7'd0) begin
          if (r.err != 8'hFF) r.err = r.err + 8'd1;
          if (!r.ffv) begin
            r.ffi = v;
            r.ffv = 1'b1;
          end
        end
      end
    end
    r.pass = (r.err == 8'd0);
    return r;
  endfunction

  logic [6:0] y1_s, y2_s;
  assign y1_s = gate_out(mode1, bus1.a, bus1.b);
  assign y2_s = gate_out(mode2, bus2.a, bus2.b);
  assign {bus1.y6, bus1.y5, bus1.y4, bus1.y3, bus1.y2, bus1.y1, bus1.y0} = y1_s;
  assign {bus2.y6, bus2.y5, bus2.y4, bus2.y3, bus2.y2, bus2.y1, bus2.y0} = y2_s;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference timing model and scoreboard producer for u_dut.
  logic [1:0] vec_q[$];
  res_t       res_q[$];
  logic       m_busy;
  logic       m_done;
  int         m_j;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_j    = 0;
      vec_q.delete();
      res_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (bus1.start) begin
          m_busy = 1'b1;
          m_j    = 0;
          for (int l = 0; l < L; l++)
            for (int n = 0; n < 4; n++) vec_q.push_back(2'(n));
          res_q.push_back(expect_run(mode1, L));
        end
      end else begin
        m_j++;
        if (m_j == RUNLEN) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // Scoreboard consumer: compares u_dut against the model on every falling edge.
  always @(negedge clk) begin
    logic [1:0] v;
    res_t r;
    if (!rst) begin
      check_eq("busy", bus1.busy, m_busy);
      check_eq("done", bus1.done, m_done);
      if (m_busy && (m_j == 0)) begin
        check_eq("accept_err_clr", bus1.err_count, 8'd0);
        check_eq("accept_fv_clr", bus1.fail_vec, 7'd0);
        check_eq("accept_ffv_clr", bus1.first_fail_valid, 1'b0);
        check_eq("accept_pass_clr", bus1.pass, 1'b0);
      end
      if (m_busy && ((m_j % (S + 1)) == 0)) begin
        if (vec_q.size() == 0) begin
          check_eq("vec_queue_empty", 32'd1, 32'd0);
        end else begin
          v = vec_q.pop_front();
          check_eq("vector", {bus1.a, bus1.b}, v);
        end
      end
      if (!m_busy) check_eq("idle_ab", {bus1.a, bus1.b}, 2'b00);
      if (m_done) begin
        if (res_q.size() == 0) begin
          check_eq("res_queue_empty", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check_eq("err_count", bus1.err_count, r.err);
          check_eq("fail_vec", bus1.fail_vec, r.fv);
          check_eq("first_fail_valid", bus1.first_fail_valid, r.ffv);
          if (r.ffv) check_eq("first_fail_idx", bus1.first_fail_idx, r.ffi);
          check_eq("pass", bus1.pass, r.pass);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mode1      = 0;
    mode2      = 2;
    rst        = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", bus1.busy, 1'b0);
    check_eq("rst_done", bus1.done, 1'b0);
    check_eq("rst_ab", {bus1.a, bus1.b}, 2'b00);
    check_eq("rst_pass", bus1.pass, 1'b0);
    check_eq("rst_err", bus1.err_count, 8'd0);
    check_eq("rst_fv", bus1.fail_vec, 7'd0);
    check_eq("rst_ffi", bus1.first_fail_idx, 2'd0);
    check_eq("rst_ffv", bus1.first_fail_valid, 1'b0);
    rst = 1'b0;

    // Correct gate block.
    pulse_start();
    repeat (16) @(negedge clk);

    // y4 stuck at 0: expect err 2, fail_vec 0010000, first fail 01.
    mode1 = 1;
    check_eq("model_y4_err", 32'(expect_run(1, 1).err), 32'd2);
    pulse_start();
    repeat (16) @(negedge clk);
    check_eq("hold_err", bus1.err_count, 8'd2);
    check_eq("hold_fv", bus1.fail_vec, 7'b0010000);
    check_eq("hold_ffi", bus1.first_fail_idx, 2'b01);
    check_eq("hold_pass", bus1.pass, 1'b0);

    // Second start at k+5 while busy is ignored.
    mode1 = 0;
    pulse_start();
    repeat (3) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (14) @(negedge clk);

    // Asynchronous reset at k+7 during a failing run.
    mode1 = 1;
    pulse_start();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", bus1.busy, 1'b0);
    check_eq("arst_ab", {bus1.a, bus1.b}, 2'b00);
    check_eq("arst_err", bus1.err_count, 8'd0);
    check_eq("arst_fv", bus1.fail_vec, 7'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (16) @(negedge clk);

    // Start held high: back-to-back runs; saturation run in parallel.
    mode1      = 0;
    bus1.start = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (3 * (RUNLEN + 1) + 2) @(negedge clk);
    bus1.start = 1'b0;
    repeat (16) @(negedge clk);

    for (int i = 0; i < 2000 && !bus2.done; i++) @(negedge clk);
    check_eq("sat_done_seen", bus2.done, 1'b1);
    check_eq("sat_err", bus2.err_count, 8'd255);
    check_eq("sat_fv", bus2.fail_vec, 7'h7F);
    check_eq("sat_ffi", bus2.first_fail_idx, 2'b00);
    check_eq("sat_ffv", bus2.first_fail_valid, 1'b1);
    check_eq("sat_pass", bus2.pass, 1'b0);
    @(negedge clk);
    check_eq("sat_done_fall", bus2.done, 1'b0);
    check_eq("sat_err_hold", bus2.err_count, 8'd255);

    check_eq("vec_q_drained", vec_q.size(), 32'd0);
    check_eq("res_q_drained", res_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
